// File: rtl/search_logic.sv
// Three-stage pipelined TCAM search: key register, chunk-match capture and a
// priority-encoded result register, all advancing together under back-pressure.
module search_logic #(
    parameter int unsigned TCAM_DEPTH = 512,
    parameter int unsigned TCAM_WIDTH = 40,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [TCAM_WIDTH-1:0]                s_key,
    input  logic                                 s_key_valid,
    output logic                                 s_key_ready,
    input  logic                                 wr_busy,
    output logic [TCAM_WIDTH-1:0]                lut_addr,
    input  logic [TCAM_DEPTH*TCAM_WIDTH/5-1:0]   lut_match,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 m_hit,
    output logic                                 m_multi,
    output logic                                 m_err,
    output logic [ADDR_WIDTH-1:0]                m_addr,
    output logic [15:0]                          hit_count
);

    localparam int unsigned NUM_CHUNKS = TCAM_WIDTH / 5;

    logic                  r_s0_valid;
    logic [TCAM_WIDTH-1:0] r_key;
    logic                  r_s1_valid;
    logic [TCAM_DEPTH-1:0] r_match;
    logic                  r_s1_err;
    logic                  r_s2_valid;
    logic                  r_hit;
    logic                  r_multi;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_hit_count;

    logic                  w_advance;
    logic                  w_key_xfer;
    logic                  w_deliver;
    logic [TCAM_DEPTH-1:0] w_match;
    logic                  w_hit;
    logic                  w_multi;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_advance   = ~r_s2_valid | m_ready;
    // Reset gates ready directly so it drops without waiting for a clock.
    assign s_key_ready = rst & w_advance & ~wr_busy;
    assign w_key_xfer  = s_key_valid & s_key_ready;
    assign w_deliver   = r_s2_valid & m_ready;

    // An entry matches only if every 5-bit chunk of the key matches it.
    always_comb begin
        w_match = '1;
        for (int c = 0; c < int'(NUM_CHUNKS); c++) begin
            w_match = w_match & lut_match[c*TCAM_DEPTH +: TCAM_DEPTH];
        end
    end

    // Clearing the lowest set bit leaves something behind only on a multi-hit.
    always_comb begin
        w_hit   = |r_match;
        w_multi = |(r_match & (r_match - TCAM_DEPTH'(1)));
        w_addr  = '0;
        for (int e = int'(TCAM_DEPTH) - 1; e >= 0; e--) begin
            if (r_match[e]) begin
                w_addr = ADDR_WIDTH'(e);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0_valid <= 1'b0;
            r_key      <= '0;
        end else if (w_advance) begin
            r_s0_valid <= w_key_xfer;
            if (w_key_xfer) begin
                r_key <= s_key;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_match    <= '0;
            r_s1_err   <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= r_s0_valid;
            r_match    <= w_match;
            r_s1_err   <= wr_busy;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_hit      <= 1'b0;
            r_multi    <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_hit      <= w_hit;
            r_multi    <= w_multi;
            r_err      <= r_s1_err;
            r_addr     <= w_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_count <= '0;
        end else if (w_deliver && r_hit && (r_hit_count != 16'hFFFF)) begin
            r_hit_count <= r_hit_count + 16'd1;
        end
    end

    assign lut_addr  = r_key;
    assign m_valid   = r_s2_valid;
    assign m_hit     = r_hit;
    assign m_multi   = r_multi;
    assign m_err     = r_err;
    assign m_addr    = r_addr;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_search_logic.sv
// Bench for search_logic: emulates SRL chunk reads from a ternary entry table and
// scores every delivered result against a whole-key search of that table.
module tb_search_logic;

    localparam int D  = 512;
    localparam int W  = 40;
    localparam int AW = 9;
    localparam int C  = W / 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  s_key;
    logic          s_key_valid;
    logic          s_key_ready;
    logic          wr_busy;
    logic [W-1:0]  lut_addr;
    logic [D*C-1:0] lut_match;
    logic          m_valid;
    logic          m_ready;
    logic          m_hit;
    logic          m_multi;
    logic          m_err;
    logic [AW-1:0] m_addr;
    logic [15:0]   hit_count;

    always #5 clk = ~clk;

    search_logic #(.TCAM_DEPTH(D), .TCAM_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_key      (s_key),
        .s_key_valid(s_key_valid),
        .s_key_ready(s_key_ready),
        .wr_busy    (wr_busy),
        .lut_addr   (lut_addr),
        .lut_match  (lut_match),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_hit      (m_hit),
        .m_multi    (m_multi),
        .m_err      (m_err),
        .m_addr     (m_addr),
        .hit_count  (hit_count)
    );

    logic [W-1:0] ent_val  [D];
    logic [W-1:0] ent_care [D];

    // SRL read emulation: one bit per (chunk, entry).
    always_comb begin
        lut_match = '0;
        for (int c = 0; c < C; c++) begin
            for (int e = 0; e < D; e++) begin
                lut_match[c*D+e] =
                    (((lut_addr[c*5 +: 5] ^ ent_val[e][c*5 +: 5]) & ent_care[e][c*5 +: 5]) == 5'd0);
            end
        end
    end

    typedef struct {
        logic          hit;
        logic          multi;
        logic          err;
        logic [AW-1:0] addr;
    } res_t;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   model_hc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t ref_search(input logic [W-1:0] k);
        res_t r;
        int   n = 0;
        r.addr = '0;
        for (int e = 0; e < D; e++) begin
            if (((k ^ ent_val[e]) & ent_care[e]) == '0) begin
                if (n == 0) r.addr = AW'(e);
                n++;
            end
        end
        r.hit   = (n > 0);
        r.multi = (n > 1);
        r.err   = 1'b0;
        return r;
    endfunction

    // Scoreboard: record accepted keys, check delivered results in order.
    always @(negedge clk) begin
        res_t r;
        if (rst) begin
            chk("hit_count", hit_count, model_hc);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_result: got addr %0d, expected none (t=%0t)",
                             m_addr, $time);
                end else begin
                    r = exp_q.pop_front();
                    chk("m_hit", m_hit, r.hit);
                    chk("m_multi", m_multi, r.multi);
                    chk("m_err", m_err, r.err);
                    chk("m_addr", m_addr, r.addr);
                    if (r.hit && model_hc < 65535) model_hc++;
                end
            end
            if (s_key_valid && s_key_ready) begin
                r = ref_search(s_key);
                exp_q.push_back(r);
            end
        end
    end

    // Every entry differs from k in exactly one nonzero chunk value.
    function automatic logic [W-1:0] flip_of(input int e);
        logic [W-1:0] f;
        f = W'(((e / 8) % 31) + 1) << (5 * (e % 8));
        return f;
    endfunction

    task automatic program_base(input logic [W-1:0] k);
        for (int e = 0; e < D; e++) begin
            ent_val[e]  = k ^ flip_of(e);
            ent_care[e] = '1;
        end
    endtask

    task automatic program_random();
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] cc;
        for (int e = 0; e < D; e++) begin
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            cc = {$urandom(), $urandom()};
            ent_val[e]  = a[W-1:0];
            ent_care[e] = ~(b[W-1:0] & cc[W-1:0] & a[W-1:0]);
            if (e > 0 && (e % 16) == 0) begin
                ent_val[e]  = ent_val[$urandom_range(e - 1, 0)];
                ent_care[e] = '1;
            end
        end
    endtask

    function automatic logic [W-1:0] make_key(input int j);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return (ent_val[j] & ent_care[j]) | (r[W-1:0] & ~ent_care[j]);
    endfunction

    task automatic send(input logic [W-1:0] k);
        int t = 0;
        s_key       = k;
        s_key_valid = 1'b1;
        @(negedge clk);
        while (!s_key_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        chk("send_ready", s_key_ready, 1);
        @(posedge clk);
        #1;
        s_key_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        s_key_valid = 1'b0;
        m_ready     = 1'b1;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int   ea;
        int   eb;
        logic hit;
        logic multi;
        int   addr;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] k;
        logic [W-1:0] ks[4];
        res_t         r0;
        int           lat;
        int           hits;

        tbl[0] = '{5,   -1,  1'b1, 1'b0, 5};
        tbl[1] = '{7,   300, 1'b1, 1'b1, 7};
        tbl[2] = '{-1,  -1,  1'b0, 1'b0, 0};
        tbl[3] = '{511, -1,  1'b1, 1'b0, 511};
        tbl[4] = '{0,   511, 1'b1, 1'b1, 0};
        tbl[5] = '{256, 255, 1'b1, 1'b1, 255};

        s_key = '0; s_key_valid = 1'b0; wr_busy = 1'b0; m_ready = 1'b1;
        program_base(40'h12_3456_789A);
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_key_ready", s_key_ready, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_lut_addr", lut_addr, 0);
        chk("rst_m_addr", m_addr, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", s_key_ready, 1);
        @(posedge clk); #1;

        // Single-key table: latency and result fields against fixed expectations.
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            k = {$urandom(), $urandom()};
            program_base(k);
            if (tbl[i].ea >= 0) ent_val[tbl[i].ea] = k;
            if (tbl[i].eb >= 0) ent_val[tbl[i].eb] = k;
            send(k);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!m_valid && lat < 10);
            chk("tbl_latency", lat, 3);
            chk("tbl_m_hit", m_hit, tbl[i].hit);
            chk("tbl_m_multi", m_multi, tbl[i].multi);
            chk("tbl_m_addr", m_addr, tbl[i].addr);
            chk("tbl_m_err", m_err, 0);
            if (tbl[i].hit) hits++;
            @(posedge clk); #1;
            @(negedge clk);
            chk("tbl_hit_count", hit_count, hits);
            @(posedge clk); #1;
        end

        // Back-pressure: four keys, result side stalled for five cycles.
        k = 40'hA5_5A5A_A5A5;
        program_base(k);
        ks[0] = k ^ flip_of(3);
        ks[1] = k ^ flip_of(100);
        ks[2] = k ^ flip_of(200);
        ks[3] = k ^ flip_of(77);
        r0 = ref_search(ks[0]);
        m_ready = 1'b0;
        send(ks[0]);
        send(ks[1]);
        send(ks[2]);
        s_key = ks[3];
        s_key_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", s_key_ready, 0);
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_addr", m_addr, r0.addr);
            chk("stall_m_hit", m_hit, r0.hit);
            chk("stall_m_multi", m_multi, r0.multi);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        send(ks[3]);
        drain();

        // Update engine busy: in-flight key flagged, no key accepted meanwhile.
        k = 40'h0F_F00F_F00F;
        program_base(k);
        ent_val[5] = k;
        send(k);
        wr_busy = 1'b1;
        exp_q[exp_q.size()-1].err = 1'b1;
        s_key = k;
        s_key_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("busy_ready", s_key_ready, 0);
        end
        @(posedge clk); #1;
        wr_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_ready", s_key_ready, 1);
        @(posedge clk); #1;
        s_key_valid = 1'b0;
        drain();

        // Randomized traffic against the whole-key reference search.
        program_random();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            s_key_valid = (($urandom() % 4) != 0);
            if (($urandom() % 5) == 0) begin
                ks[0] = {$urandom(), $urandom()};
                s_key = ks[0];
            end else begin
                s_key = make_key($urandom_range(D - 1, 0));
            end
            m_ready = (($urandom() % 10) < 7);
        end
        drain();

        // Reset with three keys in flight.
        send(make_key(10));
        send(make_key(20));
        send(make_key(30));
        rst = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_hit_count", hit_count, 0);
        chk("midrst_lut_addr", lut_addr, 0);
        chk("midrst_s_key_ready", s_key_ready, 0);
        chk("midrst_m_hit", m_hit, 0);
        exp_q.delete();
        model_hc = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_result", m_valid, 0);
        end
        chk("post_rst_hit_count", hit_count, 0);
        @(posedge clk); #1;

        // Saturation: enough hits to pass the top of the counter.
        k = 40'h33_CC33_CC33;
        program_base(k);
        ent_val[5] = k;
        s_key = k;
        s_key_valid = 1'b1;
        m_ready = 1'b1;
        repeat (65545) @(posedge clk);
        #1;
        drain();
        @(negedge clk);
        chk("sat_hit_count", hit_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
